// File: rtl/lcd_pkg.sv
// lcd_pkg: LCD command bytes, template field positions, hex conversion and FSM state types
package lcd_pkg;
   localparam int CW = 20;
   localparam logic [7:0] CMD_FUNC  = 8'h38;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;
   localparam logic [4:0] POS_ADDR_HI = 5'd4;
   localparam logic [4:0] POS_ADDR_LO = 5'd5;
   localparam logic [4:0] POS_RW      = 5'd14;
   localparam logic [4:0] POS_DIN_HI  = 5'd20;
   localparam logic [4:0] POS_DIN_LO  = 5'd21;
   localparam logic [4:0] POS_DOUT_HI = 5'd29;
   localparam logic [4:0] POS_DOUT_LO = 5'd30;
   typedef enum logic [2:0] {S_POWERUP, S_INIT, S_LATCH, S_LCMD, S_FETCH, S_WAIT, S_SUBST, S_CHAR} state_t;
   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_EN, PH_HOLD} phase_t;
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
      return (n <= 4'd9) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction
   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      return (i == 2'd0) ? CMD_FUNC : (i == 2'd1) ? CMD_DISP : (i == 2'd2) ? CMD_ENTRY : CMD_CLEAR;
   endfunction
endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: one LCD bus write - setup cycle, E pulse, settle wait; o_done on the last wait cycle
module lcd_bus_writer
   import lcd_pkg::*;
#(
   parameter int T_EN    = 12,
   parameter int T_CMD   = 2500,
   parameter int T_CLEAR = 82000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_start,
   input  logic       i_rs,
   input  logic [7:0] i_data,
   input  logic       i_long_wait,
   output logic       o_done,
   output logic       o_lcd_rs,
   output logic       o_lcd_e,
   output logic [7:0] o_lcd_data
);
   phase_t r_ph, w_ph_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx, w_wait_last;
   logic r_long, r_e, r_rs;
   logic [7:0] r_data;
   // a start on the done cycle chains straight into the next setup cycle
   always_comb begin
      w_wait_last = r_long ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
      o_done = (r_ph == PH_HOLD) && (r_cnt == w_wait_last);
      w_ph_nx = i_start ? PH_SETUP :
                (r_ph == PH_SETUP) ? PH_EN :
                (r_ph == PH_EN && r_cnt == CW'(T_EN - 1)) ? PH_HOLD :
                o_done ? PH_IDLE : r_ph;
      w_cnt_nx = (w_ph_nx != r_ph || r_ph == PH_IDLE) ? '0 : r_cnt + 1'b1;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ph <= PH_IDLE;
         r_cnt <= '0;
         r_e <= 1'b0;
         r_rs <= 1'b0;
         r_data <= '0;
         r_long <= 1'b0;
      end else begin
         r_ph <= w_ph_nx;
         r_cnt <= w_cnt_nx;
         r_e <= (w_ph_nx == PH_EN);
         if (i_start) begin
            r_rs <= i_rs;
            r_data <= i_data;
            r_long <= i_long_wait;
         end
      end
   end
   assign o_lcd_e = r_e;
   assign o_lcd_rs = r_rs;
   assign o_lcd_data = r_data;
endmodule

// File: rtl/lcd_status_display.sv
// lcd_status_display: initialises a 16x2 LCD then refreshes the template ROM onto it,
// substituting hex fields from a per-frame snapshot of the live bus values.
module lcd_status_display
   import lcd_pkg::*;
#(
   parameter int T_POWERUP = 750000,
   parameter int T_EN      = 12,
   parameter int T_CMD     = 2500,
   parameter int T_CLEAR   = 82000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] addr_in,
   input  logic       we_in,
   input  logic [7:0] din_in,
   input  logic [7:0] dout_in,
   output logic [4:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       ready,
   output logic       frame_done
);
   state_t r_st, w_nx;
   logic [CW-1:0] r_pwr;
   logic [1:0] r_idx;
   logic [4:0] r_pos, r_addr;
   logic r_we, r_ready, r_fd, w_start, w_rs, w_done, w_long;
   logic [7:0] r_din, r_dout, r_rom, w_char, w_byte;
   assign w_char = (r_pos == POS_ADDR_HI) ? hex_to_ascii({3'b0, r_addr[4]}) :
                   (r_pos == POS_ADDR_LO) ? hex_to_ascii(r_addr[3:0]) :
                   (r_pos == POS_RW)      ? (r_we ? 8'h57 : 8'h52) :
                   (r_pos == POS_DIN_HI)  ? hex_to_ascii(r_din[7:4]) :
                   (r_pos == POS_DIN_LO)  ? hex_to_ascii(r_din[3:0]) :
                   (r_pos == POS_DOUT_HI) ? hex_to_ascii(r_dout[7:4]) :
                   (r_pos == POS_DOUT_LO) ? hex_to_ascii(r_dout[3:0]) : r_rom;
   assign w_long = !w_rs && (w_byte == CMD_CLEAR);
   always_comb begin
      w_nx = r_st;
      w_start = 1'b0;
      w_rs = 1'b0;
      w_byte = w_char;
      case (r_st)
         S_POWERUP: if (r_pwr == CW'(T_POWERUP - 1)) begin w_start = 1'b1; w_byte = CMD_FUNC; w_nx = S_INIT; end
         S_INIT:    if (w_done && r_idx != 2'd3) begin w_start = 1'b1; w_byte = init_cmd(r_idx + 2'd1); end
                    else if (w_done) w_nx = S_LATCH;
         S_LATCH:   begin w_start = 1'b1; w_byte = CMD_LINE1; w_nx = S_LCMD; end
         S_LCMD:    if (w_done) w_nx = S_FETCH;
         S_FETCH:   w_nx = S_WAIT;
         S_WAIT:    w_nx = S_SUBST;
         S_SUBST:   begin w_start = 1'b1; w_rs = 1'b1; w_nx = S_CHAR; end
         S_CHAR:    if (w_done && r_pos == 5'd15) begin w_start = 1'b1; w_byte = CMD_LINE2; w_nx = S_LCMD; end
                    else if (w_done) w_nx = (r_pos == 5'd31) ? S_LATCH : S_FETCH;
         default:   w_nx = S_POWERUP;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_st <= S_POWERUP;
         r_pwr <= '0;
         r_idx <= '0;
         r_pos <= '0;
         r_ready <= 1'b0;
         r_fd <= 1'b0;
         r_addr <= '0;
         r_we <= 1'b0;
         r_din <= '0;
         r_dout <= '0;
         r_rom <= '0;
      end else begin
         r_st <= w_nx;
         r_pwr <= (r_st == S_POWERUP) ? r_pwr + 1'b1 : '0;
         r_idx <= (r_st == S_INIT && w_done) ? r_idx + 2'd1 : r_idx;
         r_pos <= (r_st == S_LATCH) ? '0 : (r_st == S_CHAR && w_done) ? r_pos + 5'd1 : r_pos;
         r_ready <= r_ready | (r_st == S_INIT && w_done && r_idx == 2'd3);
         r_fd <= (r_st == S_CHAR) && w_done && (r_pos == 5'd31);
         if (r_st == S_WAIT) r_rom <= rom_data;
         if (r_st == S_LATCH) begin
            r_addr <= addr_in;
            r_we <= we_in;
            r_din <= din_in;
            r_dout <= dout_in;
         end
      end
   end
   lcd_bus_writer #(.T_EN(T_EN), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)) u_writer (
      .clock(clock),
      .reset(reset),
      .i_start(w_start),
      .i_rs(w_rs),
      .i_data(w_byte),
      .i_long_wait(w_long),
      .o_done(w_done),
      .o_lcd_rs(lcd_rs),
      .o_lcd_e(lcd_e),
      .o_lcd_data(lcd_data)
   );
   assign rom_addr = r_pos;
   assign lcd_rw = 1'b0;
   assign ready = r_ready;
   assign frame_done = r_fd;
endmodule
